// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator operand loader.
// Holds the default geometry, the bus address map, the CTRL register bit
// positions and the sequencer state encoding.
package acc_pkg;
  localparam int DAT_SIZE_DEF = 8;
  localparam int LANES_DEF    = 4;
  localparam int DEPTH_DEF    = 256;
  localparam int COMP_LAT_DEF = 2;

  typedef logic [LANES_DEF-1:0][DAT_SIZE_DEF-1:0] word_t;

  localparam logic [11:0] A_BASE    = 12'h000;
  localparam logic [11:0] B_BASE    = 12'h400;
  localparam logic [11:0] C_BASE    = 12'h800;
  localparam logic [11:0] CTRL_ADDR = 12'hC00;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/acc_buf_wr.sv
// DEPTH x word operand buffer with a lane-enable write port, an async read
// port and the whole array exposed in parallel for the accelerator.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears the array)
//   i_we      - write strobe
//   i_idx     - write word index
//   i_be      - per-lane write enables
//   i_wdata   - write word
//   i_ridx    - read word index
//   o_rdata   - async read word
//   o_mem     - full array contents
module acc_buf_wr
  import acc_pkg::*;
#(
  parameter int DAT_SIZE = DAT_SIZE_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_we,
  input  logic [AW-1:0]                   i_idx,
  input  logic [LANES-1:0]                i_be,
  input  logic [LANES-1:0][DAT_SIZE-1:0]  i_wdata,
  input  logic [AW-1:0]                   i_ridx,
  output logic [LANES-1:0][DAT_SIZE-1:0]  o_rdata,
  output logic [LANES-1:0][DAT_SIZE-1:0]  o_mem [DEPTH]
);
  logic [LANES-1:0][DAT_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_be[l]) r_mem[i_idx][l] <= i_wdata[l];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];
  assign o_mem   = r_mem;
endmodule

// File: rtl/acc_loader.sv
// Feeder/control stage in front of the matrix-multiply accelerator.
// A zero-wait bus slave holds operand buffers A and B (driven out in parallel),
// sequences a fixed-latency compute window, snapshots acc_out into buffer C
// and flags completion through a sticky DONE bit and a one-cycle irq.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   bus_req/we/be/addr/wdata - core-side request
//   bus_gnt             - grant (combinational, equals bus_req)
//   bus_rvalid/rdata    - response, one cycle after each granted request
//   acc_in_A, acc_in_B  - operand arrays to the accelerator
//   acc_out             - accelerator result array
//   busy                - compute window in progress
//   irq                 - one-cycle completion pulse
module acc_loader
  import acc_pkg::*;
#(
  parameter int DAT_SIZE = DAT_SIZE_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int COMP_LAT = COMP_LAT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bus_req,
  input  logic                            bus_we,
  input  logic [LANES-1:0]                bus_be,
  input  logic [11:0]                     bus_addr,
  input  logic [LANES*DAT_SIZE-1:0]       bus_wdata,
  output logic                            bus_gnt,
  output logic                            bus_rvalid,
  output logic [LANES*DAT_SIZE-1:0]       bus_rdata,
  output logic [LANES-1:0][DAT_SIZE-1:0]  acc_in_A [DEPTH],
  output logic [LANES-1:0][DAT_SIZE-1:0]  acc_in_B [DEPTH],
  input  logic [LANES-1:0][DAT_SIZE-1:0]  acc_out  [DEPTH],
  output logic                            busy,
  output logic                            irq
);
  localparam int W  = LANES * DAT_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;
  localparam logic [1:0] RG_A = A_BASE[11:10];
  localparam logic [1:0] RG_B = B_BASE[11:10];
  localparam logic [1:0] RG_C = C_BASE[11:10];

  state_t                          r_state;
  logic [CW-1:0]                   r_cnt;
  logic                            r_done;
  logic                            r_irq;
  logic                            r_rvalid;
  logic [W-1:0]                    r_rdata;
  logic [LANES-1:0][DAT_SIZE-1:0]  r_c [DEPTH];

  logic [1:0]                      w_region;
  logic [AW-1:0]                   w_idx;
  logic                            w_idle;
  logic                            w_wr;
  logic                            w_is_ctrl;
  logic                            w_ctrl_wr;
  logic                            w_start;
  logic                            w_clr;
  logic [LANES-1:0][DAT_SIZE-1:0]  w_rd_a;
  logic [LANES-1:0][DAT_SIZE-1:0]  w_rd_b;
  logic [W-1:0]                    w_rd;
  logic                            w_unused;

  // Byte offset within a word carries no meaning on this bus.
  assign w_unused  = ^bus_addr[1:0];

  assign w_region  = bus_addr[11:10];
  assign w_idx     = bus_addr[2 +: AW];
  assign w_idle    = (r_state == IDLE);
  assign w_wr      = bus_req & bus_we;
  assign w_is_ctrl = (bus_addr[11:2] == CTRL_ADDR[11:2]);
  assign w_ctrl_wr = w_wr & w_is_ctrl & bus_be[0];
  assign w_start   = w_ctrl_wr & bus_wdata[CTRL_START] & w_idle;
  assign w_clr     = w_ctrl_wr & bus_wdata[CTRL_DONE];

  assign bus_gnt    = bus_req;
  assign bus_rvalid = r_rvalid;
  assign bus_rdata  = r_rdata;
  assign busy       = ~w_idle;
  assign irq        = r_irq;

  // Operand writes are only accepted while idle so the multiplier sees
  // stable inputs for the whole compute window.
  acc_buf_wr #(.DAT_SIZE(DAT_SIZE), .LANES(LANES), .DEPTH(DEPTH)) u_buf_a (
    .clk(clk), .rst(rst),
    .i_we(w_wr & w_idle & (w_region == RG_A)),
    .i_idx(w_idx), .i_be(bus_be), .i_wdata(bus_wdata),
    .i_ridx(w_idx), .o_rdata(w_rd_a), .o_mem(acc_in_A)
  );

  acc_buf_wr #(.DAT_SIZE(DAT_SIZE), .LANES(LANES), .DEPTH(DEPTH)) u_buf_b (
    .clk(clk), .rst(rst),
    .i_we(w_wr & w_idle & (w_region == RG_B)),
    .i_idx(w_idx), .i_be(bus_be), .i_wdata(bus_wdata),
    .i_ridx(w_idx), .o_rdata(w_rd_b), .o_mem(acc_in_B)
  );

  always_comb begin
    w_rd = '0;
    case (w_region)
      RG_A:    w_rd = w_rd_a;
      RG_B:    w_rd = w_rd_b;
      RG_C:    w_rd = r_c[w_idx];
      default: begin
        if (w_is_ctrl) begin
          w_rd[CTRL_BUSY] = ~w_idle;
          w_rd[CTRL_DONE] = r_done;
        end
      end
    endcase
  end

  // Response stage: one cycle after the request, zero data for writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= bus_req;
      r_rdata  <= (bus_req & ~bus_we) ? w_rd : '0;
    end
  end

  // Sequencer: counter is loaded with COMP_LAT-1 so COMPUTE lasts COMP_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= COMPUTE;
            r_cnt   <= CW'(COMP_LAT - 1);
          end
        end
        COMPUTE: begin
          if (r_cnt == '0) r_state <= CAPTURE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        CAPTURE: begin
          r_state <= IDLE;
          r_irq   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      // Completion set has priority over a concurrent clear.
      if (r_state == CAPTURE)  r_done <= 1'b1;
      else if (w_start | w_clr) r_done <= 1'b0;
    end
  end

  // Result snapshot taken in the single CAPTURE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_c[i] <= '0;
    end else if (r_state == CAPTURE) begin
      r_c <= acc_out;
    end
  end
endmodule

// File: tb/tb_acc_loader.sv
module tb_acc_loader;
  import acc_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_be = 4'h0;
  logic [11:0] bus_addr = 12'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  word_t       acc_in_A [256];
  word_t       acc_in_B [256];
  word_t       acc_out  [256];
  logic        busy;
  logic        irq;

  acc_loader #(.DAT_SIZE(8), .LANES(4), .DEPTH(256), .COMP_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .acc_in_A(acc_in_A), .acc_in_B(acc_in_B),
    .acc_out(acc_out), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Stand-in accelerator: lanewise sum of the operands.
  always_comb begin
    for (int i = 0; i < 256; i++)
      for (int l = 0; l < 4; l++)
        acc_out[i][l] = acc_in_A[i][l] + acc_in_B[i][l];
  end

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  // Reference model: buffer contents, DONE flag and the cycle a run started.
  word_t mA [256];
  word_t mB [256];
  word_t mC [256];
  bit    m_done;
  bit    m_started;
  int    m_s;
  int    n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  function automatic bit mbusy();
    return m_started && (n >= m_s + 1) && (n <= m_s + LAT + 1);
  endfunction

  function automatic bit mirq();
    return m_started && (n == m_s + LAT + 2);
  endfunction

  function automatic word_t lane_add(input word_t a, input word_t b);
    word_t r;
    for (int l = 0; l < 4; l++) r[l] = a[l] + b[l];
    return r;
  endfunction

  function automatic word_t merge(input word_t old, input logic [31:0] nw, input logic [3:0] be);
    word_t r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[l] = nw[l*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [11:0] a);
    int idx;
    idx = int'(a[9:2]);
    case (a[11:10])
      2'd0:    return mA[idx];
      2'd1:    return mB[idx];
      2'd2:    return mC[idx];
      default: return (a[9:2] == 8'd0) ? {29'd0, m_done, mbusy(), 1'b0} : 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      mA[i] = '0; mB[i] = '0; mC[i] = '0;
    end
    m_done = 1'b0; m_started = 1'b0; m_s = 0; n = 0;
  endtask

  // One bus cycle: drive, check cycle-n outputs, advance model, check response.
  task automatic step(input bit req, input bit we, input logic [3:0] be,
                      input logic [11:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
    logic [31:0] exp;
    bit          b;
    int          idx;
    bus_req = req; bus_we = we; bus_be = be; bus_addr = addr; bus_wdata = wd;
    #1;
    chk("gnt", 32'(bus_gnt), 32'(req));
    chk("busy", 32'(busy), 32'(mbusy()));
    chk("irq", 32'(irq), 32'(mirq()));
    irq_cnt += int'(irq);
    exp = (req && !we) ? mread(addr) : 32'd0;
    b   = mbusy();
    idx = int'(addr[9:2]);
    if (m_started && n == m_s + LAT + 1) begin
      for (int i = 0; i < 256; i++) mC[i] = lane_add(mA[i], mB[i]);
      m_done = 1'b1;
    end else if (req && we && addr[11:2] == 10'h300 && be[0]) begin
      if (wd[0] && !b) begin
        m_started = 1'b1; m_s = n; m_done = 1'b0;
      end else if (wd[2]) begin
        m_done = 1'b0;
      end
    end
    if (req && we && !b && addr[11:10] == 2'd0) mA[idx] = merge(mA[idx], wd, be);
    if (req && we && !b && addr[11:10] == 2'd1) mB[idx] = merge(mB[idx], wd, be);
    @(posedge clk);
    #1;
    chk("rvalid", 32'(bus_rvalid), 32'(req));
    if (req) chk("rdata", bus_rdata, exp);
    rd = bus_rdata;
    bus_req = 1'b0;
    n++;
  endtask

  task automatic do_reset();
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 12'h000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; bus_req = 1'b0;
    model_clear();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
  endtask

  typedef struct {
    bit          req;
    bit          we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wd;
    bit          do_chk;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t        tbl [$];
  logic [31:0] rd;

  initial begin
    // Directed table: reset reads, byte enables, one full run, dropped writes.
    tbl.push_back('{1, 0, 4'hF, 12'h000, 32'h0,        1, 32'h0,        "rd_A0_rst"});
    tbl.push_back('{1, 0, 4'hF, 12'h400, 32'h0,        1, 32'h0,        "rd_B0_rst"});
    tbl.push_back('{1, 0, 4'hF, 12'h800, 32'h0,        1, 32'h0,        "rd_C0_rst"});
    tbl.push_back('{1, 0, 4'hF, 12'hC00, 32'h0,        1, 32'h0,        "rd_CTRL_rst"});
    tbl.push_back('{1, 1, 4'hF, 12'h00C, 32'hFFFFFFFF, 1, 32'h0,        "wr_A3_full"});
    tbl.push_back('{1, 1, 4'h5, 12'h00C, 32'h04030201, 1, 32'h0,        "wr_A3_be"});
    tbl.push_back('{1, 0, 4'hF, 12'h00E, 32'h0,        1, 32'hFF03FF01, "rd_A3_be"});
    tbl.push_back('{1, 1, 4'hF, 12'h000, 32'h01010101, 0, 32'h0,        "wr_A0"});
    tbl.push_back('{1, 1, 4'hF, 12'h400, 32'h02020202, 0, 32'h0,        "wr_B0"});
    tbl.push_back('{1, 1, 4'h1, 12'hC00, 32'h00000001, 0, 32'h0,        "start"});
    tbl.push_back('{0, 0, 4'h0, 12'h000, 32'h0,        0, 32'h0,        "idle1"});
    tbl.push_back('{1, 0, 4'hF, 12'hC00, 32'h0,        1, 32'h00000002, "rd_CTRL_busy"});
    tbl.push_back('{1, 0, 4'hF, 12'h800, 32'h0,        1, 32'h0,        "rd_C0_old"});
    tbl.push_back('{1, 0, 4'hF, 12'h800, 32'h0,        1, 32'h03030303, "rd_C0_new"});
    tbl.push_back('{1, 0, 4'hF, 12'hC00, 32'h0,        1, 32'h00000004, "rd_CTRL_done"});
    tbl.push_back('{1, 1, 4'hF, 12'h900, 32'hDEADBEEF, 1, 32'h0,        "wr_C_drop"});
    tbl.push_back('{1, 1, 4'hF, 12'hC08, 32'hFFFFFFFF, 1, 32'h0,        "wr_C08_drop"});
    tbl.push_back('{1, 0, 4'hF, 12'h900, 32'h0,        1, 32'h0,        "rd_C64"});
    tbl.push_back('{1, 0, 4'hF, 12'hC08, 32'h0,        1, 32'h0,        "rd_C08"});
    tbl.push_back('{1, 0, 4'hF, 12'hC00, 32'h0,        1, 32'h00000004, "rd_CTRL_still"});

    do_reset();
    irq_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, rd);
      if (tbl[i].do_chk) chk(tbl[i].nm, rd, tbl[i].exp);
    end
    chk("accA3", acc_in_A[3], 32'hFF03FF01);
    chk("irq_once_tbl", 32'(irq_cnt), 32'd1);

    // Writes during busy: operand and second START must be ignored.
    step(1, 1, 4'h1, 12'hC00, 32'h4, rd);
    irq_cnt = 0;
    step(1, 1, 4'h1, 12'hC00, 32'h1, rd);
    step(1, 1, 4'hF, 12'h000, 32'hDEADBEEF, rd);
    step(1, 1, 4'h1, 12'hC00, 32'h1, rd);
    for (int i = 0; i < 8; i++) step(0, 0, 4'h0, 12'h0, 32'h0, rd);
    chk("irq_once_busy", 32'(irq_cnt), 32'd1);
    step(1, 0, 4'hF, 12'h000, 32'h0, rd);
    chk("A0_stable", rd, 32'h01010101);
    step(1, 1, 4'h1, 12'hC00, 32'h4, rd);
    step(1, 0, 4'hF, 12'hC00, 32'h0, rd);
    chk("done_clr", rd, 32'h0);

    // DONE-clear in the capture cycle loses to the set.
    step(1, 1, 4'h1, 12'hC00, 32'h1, rd);
    step(0, 0, 4'h0, 12'h0, 32'h0, rd);
    step(0, 0, 4'h0, 12'h0, 32'h0, rd);
    step(1, 1, 4'h1, 12'hC00, 32'h4, rd);
    step(1, 0, 4'hF, 12'hC00, 32'h0, rd);
    chk("set_wins", rd, 32'h4);

    // Reset mid-COMPUTE, then a fresh run.
    step(1, 1, 4'h1, 12'hC00, 32'h1, rd);
    step(0, 0, 4'h0, 12'h0, 32'h0, rd);
    do_reset();
    irq_cnt = 0;
    step(1, 0, 4'hF, 12'h000, 32'h0, rd);
    chk("rst_A0", rd, 32'h0);
    step(1, 0, 4'hF, 12'h400, 32'h0, rd);
    chk("rst_B0", rd, 32'h0);
    step(1, 0, 4'hF, 12'h800, 32'h0, rd);
    chk("rst_C0", rd, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 12'h0, 32'h0, rd);
    chk("rst_no_irq", 32'(irq_cnt), 32'd0);
    step(1, 1, 4'hF, 12'h000, 32'h050607F8, rd);
    step(1, 1, 4'hF, 12'h400, 32'h01010110, rd);
    step(1, 1, 4'h1, 12'hC00, 32'h5, rd);
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 12'h0, 32'h0, rd);
    step(1, 0, 4'hF, 12'h800, 32'h0, rd);
    chk("fresh_C0", rd, 32'h06070808);
    step(1, 0, 4'hF, 12'hC00, 32'h0, rd);
    chk("fresh_done", rd, 32'h4);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [1:0]  rg;
      logic [7:0]  idx;
      logic [11:0] a;
      bit          rq;
      bit          w;
      rg  = 2'($urandom_range(0, 3));
      idx = 8'($urandom_range(0, 7));
      if (rg == 2'd3) idx = ($urandom_range(0, 2) != 0) ? 8'd0 : 8'($urandom_range(1, 255));
      a   = {rg, idx, 2'($urandom_range(0, 3))};
      rq  = ($urandom_range(0, 9) != 0);
      w   = ($urandom_range(0, 1) == 1);
      step(rq, w, 4'($urandom), a, $urandom, rd);
    end

    begin
      int bad_a;
      int bad_b;
      bad_a = 0; bad_b = 0;
      for (int i = 0; i < 256; i++) begin
        if (acc_in_A[i] !== mA[i]) bad_a++;
        if (acc_in_B[i] !== mB[i]) bad_b++;
      end
      chk("sweep_A", 32'(bad_a), 32'd0);
      chk("sweep_B", 32'(bad_b), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_loader.md
Name: acc_loader

Overview:
- Upstream feeder and control stage for the matrix-multiply accelerator wrapper.
- Exposes a core-side req/gnt/rvalid data-bus slave that holds operand buffers A and B and drives them as acc_in_A/acc_in_B.
- Sequences a compute window, captures acc_out into result buffer C, and raises done/irq.
- Sits between the core data bus (or a peripheral interconnect) and the accelerator wrapper.

Parameters:
- DAT_SIZE, 8, bits per lane
- LANES, 4, lanes per word (word width = LANES*DAT_SIZE = 32)
- DEPTH, 256, words per buffer (A, B, C)
- COMP_LAT, 2, cycles the combinational multiplier is allowed to settle before capture (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- bus_req  in  1  request
- bus_we  in  1  1 = write
- bus_be  in  4  byte enables
- bus_addr  in  12  byte address
- bus_wdata  in  32  write data
- bus_gnt  out  1  grant
- bus_rvalid  out  1  response valid
- bus_rdata  out  32  read data
- acc_in_A  out  [LANES][DAT_SIZE] x DEPTH  operand A buffer
- acc_in_B  out  [LANES][DAT_SIZE] x DEPTH  operand B buffer
- acc_out  in  [LANES][DAT_SIZE] x DEPTH  multiplier result
- busy  out  1  compute in progress
- irq  out  1  one-cycle pulse on completion

Behaviour:
- Address map (word index = addr[9:2]; addr[1:0] ignored):
  - 0x000-0x3FF: A, read/write.
  - 0x400-0x7FF: B, read/write.
  - 0x800-0xBFF: C, read-only; writes dropped.
  - 0xC00: CTRL.
    - bit0 START: write 1 to start; reads 0.
    - bit1 BUSY: read-only.
    - bit2 DONE: sticky; write 1 to clear.
  - 0xC04-0xFFF: read 0; writes dropped.
- Bus handshake:
  - bus_gnt = bus_req (combinational, zero wait).
  - bus_rvalid asserts exactly 1 cycle after each granted request, for reads and writes alike.
  - bus_rdata is valid only while bus_rvalid is high; it is 0 for write responses.
  - Back-to-back requests are supported every cycle.
- Byte enables apply to A/B writes. The CTRL write uses byte 0 only, and only when be[0]=1.
- FSM states: IDLE, COMPUTE, CAPTURE.
  - IDLE -> COMPUTE on a granted CTRL write with wdata[0]=1 and be[0]=1. This write also clears DONE and loads the counter with COMP_LAT-1.
  - COMPUTE: counter decrements each cycle; at 0 -> CAPTURE.
  - CAPTURE: all DEPTH words of acc_out are latched into C in one cycle, then -> IDLE. DONE is set and irq pulses on the cycle the FSM re-enters IDLE.
- busy = (state != IDLE).
- Latency: the start-write cycle is cycle 0. busy is high on cycles 1..COMP_LAT+1. C is updated at the end of cycle COMP_LAT+1. irq/DONE become visible on cycle COMP_LAT+2.
- While busy:
  - A/B writes are dropped, so operands stay stable for the multiplier.
  - START writes are ignored.
  - DONE-clear writes are honoured.
  - Reads of any region are allowed; a C read returns the previous capture.
- Simultaneous events:
  - A DONE-clear write in the same cycle that DONE is set: set wins.
  - A START write that also has bit2=1 in IDLE: start semantics apply, and DONE ends up 0.
- Reset (any time, including mid-COMPUTE/CAPTURE):
  - State -> IDLE; counter 0.
  - A, B, C all 0.
  - DONE 0; busy 0; irq 0; bus_rvalid 0; bus_rdata 0.
  - An in-flight response is discarded.
- No arithmetic is performed here; data passes through bit-exact, lane 0 = bits [7:0].

Decomposition:
- Package acc_pkg:
  - DAT_SIZE/LANES/DEPTH defaults.
  - word_t = logic [LANES-1:0][DAT_SIZE-1:0].
  - Region base constants (A_BASE, B_BASE, C_BASE, CTRL_ADDR).
  - CTRL bit indices.
  - state enum {IDLE, COMPUTE, CAPTURE}.
- One natural sub-module: acc_buf_wr, a DEPTH x word buffer with byte-enable write port, async read port, and parallel full-array output. It is instantiated for A and B. C is a plain capture register array.

Test Plan:
- Reset, then read 0x000, 0x400, 0x800, 0xC00 -> all rdata 0; rvalid exactly 1 cycle after each req; irq never pulses.
- Write A[3]=0x04030201 with be=4'b0101 over prior 0xFFFFFFFF -> A[3] reads 0xFF03FF01; acc_in_A[3] reflects it the next cycle.
- Model acc_out = A+B lanewise; load A[0]=0x01010101, B[0]=0x02020202; write CTRL=1 -> busy on cycles 1..3 (COMP_LAT=2); irq pulse on cycle 4; C[0] reads 0x03030303; CTRL reads 0x4.
- During busy, write A[0]=0xDEADBEEF and CTRL=1 -> A[0] unchanged, no second run, irq pulses only once; write CTRL=0x4 after done -> CTRL reads 0.
- Assert rst during COMPUTE -> next cycle busy=0; A, B, C read 0; no irq; a fresh start then completes normally.
- Write 0x900 (C) and 0xC08 -> no state change; reads of 0xC08 return 0; rvalid still produced for every request.
